// File: rtl/uart_serial_tx.sv
// 8N1 UART transmitter: ready/valid byte input buffered in a small FIFO,
// serialized LSB first on a registered, idle-high TX line.
module uart_serial_tx #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int unsigned Cpb   = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned BaudW = (Cpb > 1) ? $clog2(Cpb) : 1;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(Cpb - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              serial_q, serial_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic push;
    logic pop;
    logic baud_end;

    assign fifo_empty = (cnt_q == '0);
    assign push       = data_in_valid && data_in_ready;
    assign baud_end   = (baud_q == BaudLast);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back frames: pop straight into START, no idle bit.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outputs: line level is registered, so it trails the state by one cycle.
    always_comb begin
        unique case (state_q)
            StIdle:  serial_d = 1'b1;
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_q[0];
            StStop:  serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
        serial_out    = serial_q;
        data_in_ready = (cnt_q != CntFull);
        busy          = (state_q != StIdle) || !fifo_empty;
    end

endmodule

// File: tb/tb_uart_serial_tx.sv
// Bench for uart_serial_tx: directed and random pushes, each cycle compared
// against a frame-schedule model of the expected line, ready and busy.
module tb_uart_serial_tx;

    localparam int unsigned ClkFreq = 1000;
    localparam int unsigned Baud    = 100;
    localparam int unsigned Depth   = 4;
    localparam int          Cpb     = ClkFreq / Baud;
    localparam int          Frame   = 10 * Cpb;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;

    always #5 clk = ~clk;

    uart_serial_tx #(
        .CLOCK_FREQ (ClkFreq),
        .BAUD_RATE  (Baud),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: each accepted byte gets an accept edge and a start-bit edge.
    int         f_acc[$];
    int         f_st[$];
    logic [7:0] f_dat[$];
    int         last_start = -100000;

    function automatic bit m_ready(int c);
        int n = 0;
        foreach (f_acc[i]) if (f_acc[i] <= c && c < f_st[i] - 1) n++;
        return n < Depth;
    endfunction

    function automatic bit m_busy(int c);
        foreach (f_acc[i]) if (f_acc[i] <= c && c < f_st[i] + Frame - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_line(int c);
        int         idx;
        logic [7:0] d;
        foreach (f_st[i]) begin
            if (f_st[i] <= c && c < f_st[i] + Frame) begin
                idx = (c - f_st[i]) / Cpb;
                d   = f_dat[i];
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return d[idx-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        bit rdy;
        int st;
        rdy = m_ready(cyc);
        @(posedge clk);
        cyc++;
        if (reset) begin
            f_acc.delete();
            f_st.delete();
            f_dat.delete();
            last_start = -100000;
        end else if (data_in_valid && rdy) begin
            st = (cyc + 2 > last_start + Frame) ? cyc + 2 : last_start + Frame;
            f_acc.push_back(cyc);
            f_st.push_back(st);
            f_dat.push_back(data_in);
            last_start = st;
        end
        @(negedge clk);
        chk("serial_out", serial_out, m_line(cyc));
        chk("data_in_ready", data_in_ready, m_ready(cyc));
        chk("busy", busy, m_busy(cyc));
    endtask

    task automatic idle(input int n);
        data_in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push1(input logic [7:0] b);
        data_in_valid = 1'b1;
        data_in       = b;
        tick();
        data_in_valid = 1'b0;
    endtask

    initial begin
        int s_a;
        reset         = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Single byte
        idle(3);
        push1(8'hA5);
        idle(110);

        // Three back-to-back frames
        push1(8'h01);
        push1(8'h02);
        push1(8'h03);
        idle(320);

        // Hold valid with incrementing data until the FIFO fills
        data_in = 8'($urandom);
        data_in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            data_in = data_in + 8'd1;
        end
        idle(600);

        // Reset during d[3] of 0x3C with two bytes queued
        push1(8'h3C);
        s_a = f_st[f_st.size()-1];
        push1(8'($urandom));
        push1(8'($urandom));
        while (cyc < s_a + 43) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(300);

        // Push on the edge the STOP bit ends, one byte queued
        push1(8'($urandom));
        s_a = f_st[f_st.size()-1];
        push1(8'($urandom));
        while (cyc < s_a + Frame - 2) tick();
        push1(8'($urandom));
        idle(350);

        // Valid on the first cycle after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push1(8'($urandom));
        idle(120);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            data_in_valid = ($urandom_range(0, 5) == 0);
            data_in       = 8'($urandom);
            reset         = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        idle(700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
